// File: rtl/text_pkg.sv
// Shared constants and state encoding for the text cursor controller.
package text_pkg;

  localparam int COLS   = 40;
  localparam int ROWS   = 20;
  localparam int CELL_W = 8;
  localparam int CELL_H = 11;

  localparam logic [6:0] ASC_BS  = 7'h08;
  localparam logic [6:0] ASC_CR  = 7'h0D;
  localparam logic [6:0] ASC_SP  = 7'h20;
  localparam logic [6:0] ASC_MAX = 7'h7E;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    DECODE,
    ISSUE,
    RELEASE
  } state_t;

  // row*11 built from shifts so no multiplier is needed
  function automatic logic [8:0] rowToY(input logic [4:0] row);
    logic [8:0] r;
    r = {4'b0000, row};
    return (r << 3) + (r << 1) + r;
  endfunction

endpackage

// File: rtl/key_fifo.sv
// Small pointer-based keystroke FIFO with full/empty flags and a drop strobe.
module key_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 7
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             drop_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wrPtr_q, wrPtr_d;
  logic [AW:0]      rdPtr_q, rdPtr_d;
  logic             doPush, doPop;

  assign empty_o = (wrPtr_q == rdPtr_q);
  assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                   (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);

  // A pop frees a slot in the same cycle, so a push into a full FIFO
  // is still accepted when it coincides with a pop.
  assign doPop   = pop_i && !empty_o;
  assign doPush  = push_i && (!full_o || doPop);
  assign drop_o  = push_i && !doPush;
  assign data_o  = mem_q[rdPtr_q[AW-1:0]];

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    if (doPush) wrPtr_d = wrPtr_q + PTR_ONE;
    if (doPop)  rdPtr_d = rdPtr_q + PTR_ONE;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (doPush) mem_q[wrPtr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/text_cursor_ctrl.sv
// Keystroke-to-glyph scheduler: queues keys, tracks the 40x20 cursor and
// drives the renderer go/ready handshake, one glyph per printable key.
module text_cursor_ctrl
  import text_pkg::*;
#(
  parameter int GO_HOLD = 96,
  parameter int DEPTH   = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key_valid_i,
  input  logic [6:0] key_ascii_i,
  input  logic       ready_i,
  output logic       go_o,
  output logic [6:0] ascii_o,
  output logic [8:0] cell_x_o,
  output logic [8:0] cell_y_o,
  output logic       busy_o,
  output logic       overflow_o
);

  localparam int HW = $clog2(GO_HOLD + 1);

  state_t        state_q, state_d;
  logic [5:0]    col_q, col_d;
  logic [4:0]    row_q, row_d;
  logic [6:0]    curKey_q, curKey_d;
  logic [6:0]    ascii_q, ascii_d;
  logic          printable_q, printable_d;
  logic [HW-1:0] holdCnt_q, holdCnt_d;
  logic [8:0]    cellX_q, cellY_q;
  logic          overflow_q;

  logic          fifoPop, fifoEmpty, fifoFull, fifoDrop;
  logic [6:0]    fifoData;

  assign fifoPop = (state_q == IDLE) && !fifoEmpty;

  key_fifo #(.DEPTH(DEPTH), .WIDTH(7)) u_fifo (
    .clock  (clock),
    .reset  (reset),
    .push_i (key_valid_i),
    .data_i (key_ascii_i),
    .pop_i  (fifoPop),
    .data_o (fifoData),
    .empty_o(fifoEmpty),
    .full_o (fifoFull),
    .drop_o (fifoDrop)
  );

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    curKey_d    = curKey_q;
    ascii_d     = ascii_q;
    printable_d = printable_q;
    holdCnt_d   = '0;
    case (state_q)
      INIT: if (ready_i) state_d = IDLE;
      IDLE: begin
        if (!fifoEmpty) begin
          curKey_d = fifoData;
          state_d  = DECODE;
        end
      end
      DECODE: begin
        state_d = IDLE;
        if (curKey_q >= ASC_SP && curKey_q <= ASC_MAX) begin
          ascii_d     = curKey_q;
          printable_d = 1'b1;
          state_d     = ISSUE;
        end else if (curKey_q == ASC_BS) begin
          if (col_q != 6'd0 || row_q != 5'd0) begin
            if (col_q == 6'd0) begin
              col_d = 6'(COLS - 1);
              row_d = row_q - 5'd1;
            end else begin
              col_d = col_q - 6'd1;
            end
            ascii_d     = ASC_SP;
            printable_d = 1'b0;
            state_d     = ISSUE;
          end
        end else if (curKey_q == ASC_CR) begin
          col_d = 6'd0;
          row_d = (row_q == 5'(ROWS - 1)) ? 5'd0 : row_q + 5'd1;
        end
      end
      ISSUE: begin
        holdCnt_d = holdCnt_q + HW'(1);
        if (holdCnt_q == HW'(GO_HOLD - 1)) begin
          holdCnt_d = '0;
          state_d   = RELEASE;
        end
      end
      RELEASE: begin
        if (ready_i) begin
          state_d = IDLE;
          if (printable_q) begin
            if (col_q == 6'(COLS - 1)) begin
              col_d = 6'd0;
              row_d = (row_q == 5'(ROWS - 1)) ? 5'd0 : row_q + 5'd1;
            end else begin
              col_d = col_q + 6'd1;
            end
          end
        end
      end
      default: state_d = INIT;
    endcase
  end

  // Cell coordinates load from the next cursor value so they move on the
  // same edge as the cursor and never change while go is high.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= INIT;
      col_q       <= '0;
      row_q       <= '0;
      curKey_q    <= '0;
      ascii_q     <= '0;
      printable_q <= 1'b0;
      holdCnt_q   <= '0;
      cellX_q     <= '0;
      cellY_q     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      curKey_q    <= curKey_d;
      ascii_q     <= ascii_d;
      printable_q <= printable_d;
      holdCnt_q   <= holdCnt_d;
      cellX_q     <= {col_d, 3'b000};
      cellY_q     <= rowToY(row_d);
      overflow_q  <= overflow_q | fifoDrop;
    end
  end

  assign go_o       = (state_q == ISSUE);
  assign ascii_o    = ascii_q;
  assign cell_x_o   = cellX_q;
  assign cell_y_o   = cellY_q;
  assign busy_o     = (state_q != IDLE) || !fifoEmpty;
  assign overflow_o = overflow_q;

  logic unusedFull;
  assign unusedFull = fifoFull;

endmodule

// File: tb/tb_text_cursor_ctrl.sv
// Directed bench for text_cursor_ctrl with a hand-driven renderer ready pulse.
module tb_text_cursor_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       key_valid;
  logic [6:0] key_ascii;
  logic       ready;
  logic       go;
  logic [6:0] ascii;
  logic [8:0] cell_x, cell_y;
  logic       busy, overflow;

  int vectors = 0;
  int errors  = 0;
  int glyphWaits;

  always #5 clock = ~clock;

  text_cursor_ctrl #(.GO_HOLD(96), .DEPTH(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .key_valid_i(key_valid),
    .key_ascii_i(key_ascii),
    .ready_i    (ready),
    .go_o       (go),
    .ascii_o    (ascii),
    .cell_x_o   (cell_x),
    .cell_y_o   (cell_y),
    .busy_o     (busy),
    .overflow_o (overflow)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic [6:0] code);
    @(posedge clock); #1;
    key_valid = 1'b1;
    key_ascii = code;
    @(posedge clock); #1;
    key_valid = 1'b0;
  endtask

  task automatic pulseReady();
    @(posedge clock); #1;
    ready = 1'b1;
    @(posedge clock); #1;
    ready = 1'b0;
  endtask

  task automatic checkNoGo(input string tag, input int n);
    int highs = 0;
    repeat (n) begin
      @(posedge clock); #1;
      if (go) highs++;
    end
    checkOutput(tag, highs, 0);
  endtask

  // Waits for go, measures its length and checks ascii/cell stay frozen,
  // then answers with a ready pulse as the renderer would.
  task automatic drawGlyph(input string tag, input logic [6:0] expAscii,
                           input logic [8:0] expX, input logic [8:0] expY);
    int len = 0;
    logic stable = 1'b1;
    logic sawGo;
    logic [6:0] a0;
    logic [8:0] x0, y0;
    glyphWaits = 0;
    while (!go && glyphWaits < 20) begin
      @(posedge clock); #1;
      glyphWaits++;
    end
    sawGo = go;
    a0 = ascii; x0 = cell_x; y0 = cell_y;
    while (go && len < 300) begin
      len++;
      if (ascii !== a0 || cell_x !== x0 || cell_y !== y0) stable = 1'b0;
      @(posedge clock); #1;
    end
    checkOutput({tag, "_go_seen"}, sawGo, 1);
    checkOutput({tag, "_go_len"}, len, 96);
    checkOutput({tag, "_ascii"}, a0, expAscii);
    checkOutput({tag, "_cell_x"}, x0, expX);
    checkOutput({tag, "_cell_y"}, y0, expY);
    checkOutput({tag, "_stable"}, stable, 1);
    pulseReady();
  endtask

  initial begin
    logic [6:0] k;
    int n;
    reset = 1'b0; key_valid = 1'b0; key_ascii = '0; ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("rst_go", go, 0);
    checkOutput("rst_ascii", ascii, 0);
    checkOutput("rst_cell_x", cell_x, 0);
    checkOutput("rst_cell_y", cell_y, 0);
    checkOutput("rst_busy", busy, 1);
    checkOutput("rst_overflow", overflow, 0);
    reset = 1'b1;
    idle(2);
    checkOutput("init_busy", busy, 1);
    checkNoGo("init_no_go", 5);
    pulseReady();
    checkOutput("idle_busy", busy, 0);

    applyStimulus(7'h41);
    drawGlyph("A", 7'h41, 9'd0, 9'd0);
    checkOutput("A_latency", glyphWaits, 2);
    checkOutput("A_next_x", cell_x, 8);
    checkOutput("A_next_y", cell_y, 0);

    for (int i = 1; i < 40; i++) begin
      k = 7'h41 + 7'(i % 26);
      applyStimulus(k);
      drawGlyph($sformatf("row0_%0d", i), k, 9'(i * 8), 9'd0);
    end
    checkOutput("wrap_x", cell_x, 0);
    checkOutput("wrap_y", cell_y, 11);

    applyStimulus(7'h08);
    drawGlyph("bs", 7'h20, 9'd312, 9'd0);
    checkOutput("bs_after_x", cell_x, 312);
    checkOutput("bs_after_y", cell_y, 0);

    for (int i = 0; i < 19; i++) begin
      applyStimulus(7'h0D);
      idle(2);
    end
    idle(2);
    checkOutput("cr19_x", cell_x, 0);
    checkOutput("cr19_y", cell_y, 209);
    applyStimulus(7'h0D);
    checkNoGo("cr_wrap_no_go", 8);
    checkOutput("cr_wrap_x", cell_x, 0);
    checkOutput("cr_wrap_y", cell_y, 0);

    applyStimulus(7'h07);
    checkNoGo("ignored_no_go", 8);
    checkOutput("ignored_x", cell_x, 0);

    applyStimulus(7'h08);
    checkNoGo("bs00_no_go", 8);
    checkOutput("bs00_x", cell_x, 0);
    checkOutput("bs00_y", cell_y, 0);
    checkOutput("bs00_busy", busy, 0);

    applyStimulus(7'h42);
    idle(2);
    checkOutput("B_go", go, 1);
    checkOutput("B_ascii", ascii, 7'h42);
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1;
      key_valid = 1'b1;
      key_ascii = 7'h61 + 7'(i);
    end
    @(posedge clock); #1;
    key_valid = 1'b0;
    checkOutput("burst_overflow", overflow, 1);
    checkOutput("burst_busy", busy, 1);
    n = 0;
    while (go && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    checkOutput("B_go_fell", go, 0);
    pulseReady();
    drawGlyph("q_a", 7'h61, 9'd8, 9'd0);
    drawGlyph("q_b", 7'h62, 9'd16, 9'd0);
    drawGlyph("q_c", 7'h63, 9'd24, 9'd0);
    drawGlyph("q_d", 7'h64, 9'd32, 9'd0);
    checkNoGo("dropped_no_go", 20);
    checkOutput("queue_done_busy", busy, 0);
    checkOutput("queue_done_x", cell_x, 40);
    checkOutput("overflow_sticky", overflow, 1);

    applyStimulus(7'h43);
    idle(10);
    checkOutput("C_go", go, 1);
    reset = 1'b0;
    #1;
    checkOutput("midrst_go", go, 0);
    checkOutput("midrst_busy", busy, 1);
    checkOutput("midrst_x", cell_x, 0);
    checkOutput("midrst_overflow", overflow, 0);
    idle(2);
    reset = 1'b1;
    applyStimulus(7'h5A);
    checkNoGo("postrst_no_go", 20);
    checkOutput("postrst_busy", busy, 1);
    pulseReady();
    drawGlyph("Z", 7'h5A, 9'd0, 9'd0);
    checkOutput("Z_next_x", cell_x, 8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/text_cursor_ctrl.md
# text_cursor_ctrl

Character-cell scheduler sitting between the PS/2 keystroke decoder and the ASCII glyph renderer. It buffers incoming keystrokes and maintains a 40×20 text cursor over the area above the y=224 divider. It sequences the renderer's go/ready handshake to draw or erase one 8×11 glyph per keystroke. It also handles wrap, Enter and Backspace.

## Interface
- `GO_HOLD`, default 96: cycles `go` is held high per glyph. Must be ≥ 90, covering 88 pixel writes plus prep and end states.
- `DEPTH`, default 4: keystroke FIFO entries, power of two.
- `clock`, in, 1: system clock (CLOCK_50).
- `reset`, in, 1: asynchronous, active-low.
- `key_valid`, in, 1: one-cycle strobe, `key_ascii` valid.
- `key_ascii`, in, 7: keystroke code.
- `ready`, in, 1: renderer idle pulse (renderer `vga_go`). One cycle high on each entry to its freeze state.
- `go`, out, 1: renderer start/hold.
- `ascii`, out, 7: code to render; stable whenever `go`=1.
- `cell_x`, out, 9: pixel x of glyph top-left, `col*8`.
- `cell_y`, out, 9: pixel y of glyph top-left, `row*11`.
- `busy`, out, 1: FSM not in IDLE or FIFO non-empty.
- `overflow`, out, 1: sticky; set when a keystroke is dropped.

## Operation
- Reset values:
  - outputs: `go`=0, `ascii`=0, `cell_x`=0, `cell_y`=0, `busy`=1, `overflow`=0.
  - internal: `col`=0, `row`=0, FIFO empty, state INIT.
- FIFO:
  - `key_valid` pushes `key_ascii`.
  - Push when full drops the key and sets `overflow`. `overflow` clears only on reset.
  - Push and pop in the same cycle when full: the pop happens and the push is accepted.
- States:
  - INIT: wait for the first `ready` pulse, i.e. renderer screen clear done → IDLE. Keys still queue.
  - IDLE: if FIFO non-empty, pop into `cur_key` → DECODE.
  - DECODE, one cycle, by `cur_key`:
    - 0x20–0x7E: `ascii`=`cur_key` → ISSUE.
    - 0x08 Backspace: if col=0,row=0, no-op → IDLE. Else step the cursor back: col-1, or col 39 of row-1 if col=0. Then `ascii`=0x20 → ISSUE.
    - 0x0D Enter: col=0, row=(row+1) mod 20 → IDLE.
    - All other codes: ignored → IDLE.
  - ISSUE: `go`=1 for exactly `GO_HOLD` cycles; hold counter → RELEASE.
  - RELEASE: `go`=0; wait for a `ready` pulse. On `ready`, if the glyph was printable, advance the cursor: col+1; col 39 wraps to col 0 of (row+1) mod 20. → IDLE.
- Cursor wrap: row 19 advancing goes to row 0 (no scroll); that row is overwritten cell by cell.
- `cell_x`/`cell_y` are registered from col/row. They update the cycle after any cursor change and are constant through ISSUE.
  - `cell_x` = {col,3'b000}.
  - `cell_y` = (row<<3)+(row<<1)+row, max 209.
- A `ready` pulse outside INIT/RELEASE is ignored.

## Timing
- Key latency:
  - `key_valid` at cycle t with FIFO empty and FSM in IDLE → FIFO entry visible t+1.
  - Popped t+1 → DECODE t+2 → `go`=1 from t+3 through t+3+GO_HOLD-1.
- Renderer returns `ready` after `go` falls, through its go_wait→freeze path. Minimum glyph period is GO_HOLD+4 cycles.
- Reset mid-ISSUE: `go` drops asynchronously, cursor returns to 0,0, FIFO is flushed, FSM → INIT. The renderer is reset by the same net.
- `ascii`, `cell_x`, `cell_y` must not change while `go`=1. The renderer samples them combinationally throughout letterAction.

## Structure
- Shared package `text_pkg`: `COLS`=40, `ROWS`=20, `CELL_W`=8, `CELL_H`=11, `ASC_BS`=7'h08, `ASC_CR`=7'h0D, `ASC_SP`=7'h20, `ASC_MAX`=7'h7E, and the state encoding (INIT, IDLE, DECODE, ISSUE, RELEASE).
- Sub-module `key_fifo` (DEPTH×7, pointer-based, full/empty flags, simultaneous push/pop).
- Cursor arithmetic and FSM stay in the top.

## Test plan
- Reset, pulse `ready` once, send 'A' (0x41) → `go` high for 96 cycles with `ascii`=0x41, `cell_x`=0, `cell_y`=0. After `ready`, `cell_x`=8.
- Send 40 printable keys → 40th glyph drawn at `cell_x`=312, `cell_y`=0. Cursor then at `cell_x`=0, `cell_y`=11.
- Cursor at col 0,row 1, send 0x08 → `ascii`=0x20 drawn at `cell_x`=312, `cell_y`=0; cursor remains there. Backspace at 0,0 → no `go` pulse.
- Send 0x0D at row 19 → no `go`; `cell_x`=0, `cell_y`=0.
- Burst 6 keys in 6 consecutive cycles during ISSUE → 4 keys queued, `overflow`=1. Queued keys render in order, one per handshake.
- Assert `reset` low mid-ISSUE → `go`=0 immediately, `busy`=1. After release, no `go` until a `ready` pulse.
